// File: rtl/cpu_controller_if.sv
// Handshake and datapath-control bundle between the instruction source, cpu_controller and the datapath.
// The master modport drives the instruction side; the slave modport is the controller.
interface cpu_controller_if;
  logic [15:0] in;
  logic        load;
  logic        s;
  logic        w;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic        write;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        err;

  modport master (
    output in, load, s,
    input  w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
           readnum, writenum, shift, ALUop, sximm8, sximm5, err
  );

  modport slave (
    input  in, load, s,
    output w, loada, loadb, loadc, loads, asel, bsel, vsel, write,
           readnum, writenum, shift, ALUop, sximm8, sximm5, err
  );
endinterface

// File: rtl/cpu_controller.sv
// Instruction register, decoder and sequencing FSM driving the lab datapath strobes.
// CONTROLLER_ILLEGAL_TRAP_EN: when defined, illegal decodes lock in ERROR (err=1) until reset.
module cpu_controller (
  input  logic             clk,
  input  logic             reset,
  cpu_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_EXEC      = 3'd5,
    ST_WRITE_REG = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam logic [2:0]  NSEL_RN  = 3'b001;
  localparam logic [2:0]  NSEL_RD  = 3'b010;
  localparam logic [2:0]  NSEL_RM  = 3'b100;
  localparam logic [15:0] IR_RESET = 16'h0000;

  state_t      state_r, next_state_s;
  logic [15:0] ir_r, ir_next_s;
  logic [2:0]  nsel_s;

  logic        w_s, loada_s, loadb_s, loadc_s, loads_s, asel_s, write_s;
  logic [1:0]  vsel_s, shift_s, aluop_s;
  logic [2:0]  regnum_s;
  logic        w_r, loada_r, loadb_r, loadc_r, loads_r, asel_r, write_r;
  logic [1:0]  vsel_r, shift_r, aluop_r;
  logic [2:0]  regnum_r;

  function automatic logic is_mov_imm(input logic [15:0] ir);
    return (ir[15:13] == 3'b110) && (ir[12:11] == 2'b10);
  endfunction

  function automatic logic is_cmp(input logic [15:0] ir);
    return (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
  endfunction

  function automatic logic [2:0] sel_reg(input logic [2:0] nsel, input logic [15:0] ir);
    case (nsel)
      NSEL_RD: return ir[7:5];
      NSEL_RM: return ir[2:0];
      default: return ir[10:8];
    endcase
  endfunction

  // IR only accepts a new word while idle.
  always_comb begin
    if (bus.load && (state_r == ST_WAIT)) begin
      ir_next_s = bus.in;
    end else begin
      ir_next_s = ir_r;
    end
  end

  // State and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_WAIT;
      ir_r    <= IR_RESET;
    end else begin
      state_r <= next_state_s;
      ir_r    <= ir_next_s;
    end
  end

  // Next-state sequencing; DECODE and EXEC look at the captured IR.
  always_comb begin
    next_state_s = ST_WAIT;
    case (state_r)
      ST_WAIT: begin
        if (bus.s) next_state_s = ST_DECODE;
        else       next_state_s = ST_WAIT;
      end
      ST_DECODE: begin
        case ({ir_r[15:13], ir_r[12:11]})
          5'b110_10: next_state_s = ST_WRITE_IMM;
          5'b110_00: next_state_s = ST_GET_B;
          5'b101_11: next_state_s = ST_GET_B;
          5'b101_00, 5'b101_01, 5'b101_10: next_state_s = ST_GET_A;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
          default:   next_state_s = ST_ERROR;
`else
          default:   next_state_s = ST_WAIT;
`endif
        endcase
      end
      ST_WRITE_IMM: next_state_s = ST_WAIT;
      ST_GET_A:     next_state_s = ST_GET_B;
      ST_GET_B:     next_state_s = ST_EXEC;
      ST_EXEC: begin
        if (is_cmp(ir_r)) next_state_s = ST_WAIT;
        else              next_state_s = ST_WRITE_REG;
      end
      ST_WRITE_REG: next_state_s = ST_WAIT;
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
      ST_ERROR:     next_state_s = ST_ERROR;
`endif
      default:      next_state_s = ST_WAIT;
    endcase
  end

  // Moore decode of the upcoming state and IR, so the registered outputs line up with the state.
  always_comb begin
    w_s     = 1'b0;
    loada_s = 1'b0;
    loadb_s = 1'b0;
    loadc_s = 1'b0;
    loads_s = 1'b0;
    asel_s  = 1'b0;
    write_s = 1'b0;
    vsel_s  = 2'b00;
    nsel_s  = NSEL_RN;
    case (next_state_s)
      ST_WAIT:      w_s = 1'b1;
      ST_WRITE_IMM: begin
        nsel_s  = NSEL_RN;
        vsel_s  = 2'b10;
        write_s = 1'b1;
      end
      ST_GET_A: begin
        nsel_s  = NSEL_RN;
        loada_s = 1'b1;
      end
      ST_GET_B: begin
        nsel_s  = NSEL_RM;
        loadb_s = 1'b1;
      end
      ST_EXEC: begin
        asel_s = (ir_next_s[15:13] == 3'b110);
        if (is_cmp(ir_next_s)) loads_s = 1'b1;
        else                   loadc_s = 1'b1;
      end
      ST_WRITE_REG: begin
        nsel_s  = NSEL_RD;
        vsel_s  = 2'b00;
        write_s = 1'b1;
      end
      default: ;
    endcase
    regnum_s = sel_reg(nsel_s, ir_next_s);
    shift_s  = is_mov_imm(ir_next_s) ? 2'b00 : ir_next_s[4:3];
    aluop_s  = (ir_next_s[15:13] == 3'b110) ? 2'b00 : ir_next_s[12:11];
  end

  // Output registers; reset value matches the WAIT decode of IR_RESET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_r      <= 1'b1;
      loada_r  <= 1'b0;
      loadb_r  <= 1'b0;
      loadc_r  <= 1'b0;
      loads_r  <= 1'b0;
      asel_r   <= 1'b0;
      write_r  <= 1'b0;
      vsel_r   <= 2'b00;
      shift_r  <= 2'b00;
      aluop_r  <= 2'b00;
      regnum_r <= 3'b000;
    end else begin
      w_r      <= w_s;
      loada_r  <= loada_s;
      loadb_r  <= loadb_s;
      loadc_r  <= loadc_s;
      loads_r  <= loads_s;
      asel_r   <= asel_s;
      write_r  <= write_s;
      vsel_r   <= vsel_s;
      shift_r  <= shift_s;
      aluop_r  <= aluop_s;
      regnum_r <= regnum_s;
    end
  end

`ifdef CONTROLLER_ILLEGAL_TRAP_EN
  logic err_r;

  // Sticky illegal-instruction flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_r <= 1'b0;
    else       err_r <= (next_state_s == ST_ERROR);
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.w        = w_r;
  assign bus.loada    = loada_r;
  assign bus.loadb    = loadb_r;
  assign bus.loadc    = loadc_r;
  assign bus.loads    = loads_r;
  assign bus.asel     = asel_r;
  assign bus.bsel     = 1'b0;
  assign bus.vsel     = vsel_r;
  assign bus.write    = write_r;
  assign bus.readnum  = regnum_r;
  assign bus.writenum = regnum_r;
  assign bus.shift    = shift_r;
  assign bus.ALUop    = aluop_r;
  assign bus.sximm8   = {{8{ir_r[7]}}, ir_r[7:0]};
  assign bus.sximm5   = {{11{ir_r[4]}}, ir_r[4:0]};

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: the driver pushes the expected per-cycle control vectors of each
// instruction, and a negedge monitor pops and compares them while the controller is busy.
module tb_cpu_controller;

  logic clk;
  logic reset;
  cpu_controller_if bus ();

  cpu_controller dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        loada, loadb, loadc, loads, asel, bsel, write;
    logic [1:0]  vsel;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, aluop;
    logic [15:0] sx8, sx5;
  } vec_t;

  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  vec_t mon_act, mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [15:0] ins);
    case ({ins[15:13], ins[12:11]})
      5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00, 5'b101_01, 5'b101_10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: the list of busy-cycle control vectors an instruction must produce.
  task automatic push_expected(input logic [15:0] ins, output int n);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    vec_t b, v;
    opc = ins[15:13]; op = ins[12:11];
    rn = ins[10:8]; rd = ins[7:5]; rm = ins[2:0];
    b = '0;
    b.readnum = rn; b.writenum = rn;
    b.shift = (opc == 3'b110 && op == 2'b10) ? 2'b00 : ins[4:3];
    b.aluop = (opc == 3'b110) ? 2'b00 : op;
    b.sx8 = {{8{ins[7]}}, ins[7:0]};
    b.sx5 = {{11{ins[4]}}, ins[4:0]};
    exp_q.push_back(b);
    n = 1;
    if (legal(ins)) begin
      if (opc == 3'b110 && op == 2'b10) begin
        v = b; v.vsel = 2'b10; v.write = 1'b1;
        exp_q.push_back(v); n++;
      end else begin
        if (opc == 3'b101 && op != 2'b11) begin
          v = b; v.loada = 1'b1;
          exp_q.push_back(v); n++;
        end
        v = b; v.readnum = rm; v.writenum = rm; v.loadb = 1'b1;
        exp_q.push_back(v); n++;
        v = b; v.asel = (opc == 3'b110);
        if (opc == 3'b101 && op == 2'b01) v.loads = 1'b1;
        else                              v.loadc = 1'b1;
        exp_q.push_back(v); n++;
        if (!(opc == 3'b101 && op == 2'b01)) begin
          v = b; v.readnum = rd; v.writenum = rd; v.write = 1'b1;
          exp_q.push_back(v); n++;
        end
      end
    end
  endtask

  // Monitor: busy cycles are checked against the scoreboard, idle cycles must carry no strobes.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (bus.w === 1'b0) begin
        mon_act = {bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel, bus.write,
                   bus.vsel, bus.readnum, bus.writenum, bus.shift, bus.ALUop, bus.sximm8, bus.sximm5};
        if (exp_q.size() == 0) begin
          chk("busy_extra", 64'(mon_act), 64'h0 - 64'h1);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("busy_vec", 64'(mon_act), 64'(mon_exp));
        end
      end else begin
        chk("idle_strobes", 64'({bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel,
                                 bus.bsel, bus.write, bus.err, bus.vsel}), 64'h0);
      end
    end
  end

  task automatic run_instr(input logic [15:0] ins);
    int n, cnt;
    @(negedge clk);
    bus.in = ins; bus.load = 1'b1; bus.s = 1'b1;
    push_expected(ins, n);
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    cnt = 0;
    while (bus.w !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", 64'(cnt), 64'(n));
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] ins;
    ins = 16'($urandom);
    case ($urandom_range(0, 6))
      0: ins[15:11] = 5'b110_10;
      1: ins[15:11] = 5'b110_00;
      2: ins[15:11] = 5'b101_11;
      3: ins[15:11] = 5'b101_00;
      4: ins[15:11] = 5'b101_01;
      5: ins[15:11] = 5'b101_10;
      default: begin
`ifdef CONTROLLER_ILLEGAL_TRAP_EN
        ins[15:11] = 5'b101_00;
`else
        while (legal(ins)) ins = 16'($urandom);
`endif
      end
    endcase
    return ins;
  endfunction

  initial begin
    int n;
    reset = 1'b1;
    bus.in = 16'h0000; bus.load = 1'b0; bus.s = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_w", 64'(bus.w), 64'h1);
    chk("reset_strobes", 64'({bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write, bus.err}), 64'h0);
    chk("reset_ir", 64'(bus.sximm8), 64'h0);
    reset = 1'b0;
    mon_en = 1'b1;

    run_instr(16'hD007);
    run_instr(16'hD1FF);
    run_instr(16'hA148);
    run_instr(16'hA801);
    run_instr(16'hC0E3);
    run_instr(16'hB8A6);
    run_instr(16'hB25B);
`ifndef CONTROLLER_ILLEGAL_TRAP_EN
    run_instr(16'hE000);
`endif

    // Reset during GET_B of ADD, after an ignored load in GET_A.
    @(negedge clk);
    bus.in = 16'hA148; bus.load = 1'b1; bus.s = 1'b1;
    push_expected(16'hA148, n);
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    @(negedge clk);
    bus.in = 16'hD007; bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("abort_checked_3", 64'(exp_q.size()), 64'(n - 3));
    exp_q.delete();
    chk("abort_w", 64'(bus.w), 64'h1);
    chk("abort_write", 64'(bus.write), 64'h0);
    chk("abort_ir", 64'(bus.sximm8), 64'h0);
    @(negedge clk);
    chk("abort_hold", 64'({bus.w, bus.write, bus.loadc}), 64'h4);
    reset = 1'b0;

    for (int i = 0; i < 150; i++) begin
      run_instr(rand_instr());
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

`ifdef CONTROLLER_ILLEGAL_TRAP_EN
    mon_en = 1'b0;
    @(negedge clk);
    bus.in = 16'hE000; bus.load = 1'b1; bus.s = 1'b1;
    @(negedge clk);
    bus.load = 1'b0; bus.s = 1'b0;
    repeat (6) @(negedge clk);
    chk("trap_err", 64'(bus.err), 64'h1);
    chk("trap_w", 64'(bus.w), 64'h0);
    chk("trap_strobes", 64'({bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write}), 64'h0);
    reset = 1'b1;
    #1;
    chk("trap_reset", 64'({bus.w, bus.err}), 64'h2);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
